// File: rtl/regfile_dump_ctrl.sv
// Read-side dump sequencer: walks a wrapping address range of the register
// file, streams each byte over valid/ready, then sends an XOR checksum byte.
module regfile_dump_ctrl #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [3:0]        count,
    input  logic              abort,
    output logic [ADDR_W-1:0] rf_read_addr,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_CSUM
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] rf_read_addr_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_last_q;
    logic              done_q;
    logic [DATA_W-1:0] csum_q;
    logic [3:0]        remaining_q;

    // A zero or oversized request dumps the whole file.
    function automatic logic [3:0] norm_count(input logic [3:0] c);
        if (c == 4'd0 || c > 4'(DEPTH))
            return 4'(DEPTH);
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            rf_read_addr_q <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_last_q     <= 1'b0;
            done_q         <= 1'b0;
            csum_q         <= '0;
            remaining_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort && state_q != S_IDLE) begin
                state_q     <= S_IDLE;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start && !abort) begin
                            rf_read_addr_q <= start_addr;
                            remaining_q    <= norm_count(count);
                            csum_q         <= '0;
                            state_q        <= S_LOAD;
                        end
                    end
                    // The file read port is combinational, so the byte is
                    // sampled here, one cycle after the address settles.
                    S_LOAD: begin
                        out_data_q  <= rf_read_data;
                        csum_q      <= csum_q ^ rf_read_data;
                        out_last_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_SEND;
                    end
                    S_SEND: begin
                        if (out_ready) begin
                            if (remaining_q == 4'd1) begin
                                out_data_q <= csum_q;
                                out_last_q <= 1'b1;
                                state_q    <= S_CSUM;
                            end else begin
                                remaining_q    <= remaining_q - 4'd1;
                                rf_read_addr_q <= rf_read_addr_q + 1'b1;
                                out_valid_q    <= 1'b0;
                                state_q        <= S_LOAD;
                            end
                        end
                    end
                    S_CSUM: begin
                        if (out_ready) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign rf_read_addr = rf_read_addr_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_last     = out_last_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Scoreboard bench for regfile_dump_ctrl with a modelled 8x8 register file.
module tb_regfile_dump_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] start_addr;
    logic [3:0] count;
    logic       abort;
    logic [2:0] rf_read_addr;
    logic [7:0] rf_read_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic       done;

    logic [7:0] rf [8];
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;

    logic [8:0] exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         done_cnt = 0;
    int         hs_cnt   = 0;
    int         ready_mode = 0;
    logic       prev_done = 1'b0;

    always #5 clk = ~clk;

    regfile_dump_ctrl #(.ADDR_W(3), .DATA_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .start_addr   (start_addr),
        .count        (count),
        .abort        (abort),
        .rf_read_addr (rf_read_addr),
        .rf_read_data (rf_read_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done)
    );

    assign rf_read_data = rf[rf_read_addr];

    always @(posedge clk) begin
        if (wr_en) rf[wr_addr] <= wr_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Expected stream computed from the bench's own copy of the file.
    task automatic push_stream(input logic [2:0] a, input logic [3:0] c);
        int n;
        logic [7:0] cs;
        logic [2:0] ad;
        n  = (c == 4'd0 || c > 4'd8) ? 8 : int'(c);
        cs = 8'h00;
        ad = a;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({1'b0, rf[ad]});
            cs = cs ^ rf[ad];
            ad = ad + 3'd1;
        end
        exp_q.push_back({1'b1, cs});
    endtask

    task automatic start_dump(input logic [2:0] a, input logic [3:0] c);
        start_addr = a;
        count      = c;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 300; i++) begin
            if (done_cnt >= target) break;
            @(posedge clk);
            #1;
        end
        chk("done_seen", 32'(done_cnt >= target), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("done_once", 32'(done_cnt), 32'(target));
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Sink: mode 0 always ready, mode 1 stalls 5 cycles per beat, mode 2 never ready.
    initial begin
        int stall_cnt;
        stall_cnt = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (ready_mode == 0) begin
                out_ready = 1'b1;
            end else if (ready_mode == 2) begin
                out_ready = 1'b0;
            end else if (!out_valid) begin
                out_ready = 1'b0;
                stall_cnt = 0;
            end else if (stall_cnt < 5) begin
                out_ready = 1'b0;
                stall_cnt++;
            end else begin
                out_ready = 1'b1;
                stall_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst) begin
            if (out_valid && out_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    chk("extra_byte", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", 32'(out_data), 32'(e[7:0]));
                    chk("last", 32'(out_last), 32'(e[8]));
                end
            end else if (out_valid && exp_q.size() > 0) begin
                chk("hold_data", 32'(out_data), 32'(exp_q[0][7:0]));
                chk("hold_last", 32'(out_last), 32'(exp_q[0][8]));
            end
            if (done) begin
                done_cnt++;
                chk("busy_at_done", 32'(busy), 32'd0);
                chk("done_width", 32'(prev_done), 32'd0);
            end
            prev_done = done;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int target;
        int hs0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; start_addr = '0; count = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        for (int i = 0; i < 8; i++) rf[i] = 8'h10 + 8'(i);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr",  32'(rf_read_addr), 32'd0);
        chk("rst_valid", 32'(out_valid),    32'd0);
        chk("rst_data",  32'(out_data),     32'd0);
        chk("rst_last",  32'(out_last),     32'd0);
        chk("rst_busy",  32'(busy),         32'd0);
        chk("rst_done",  32'(done),         32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Wrapping range 6,7,0
        push_stream(3'd6, 4'd3);
        target = done_cnt + 1;
        start_dump(3'd6, 4'd3);
        wait_done(target);

        // Full file, count 0 and count 12
        push_stream(3'd0, 4'd0);
        target = done_cnt + 1;
        start_dump(3'd0, 4'd0);
        wait_done(target);
        push_stream(3'd0, 4'd12);
        target = done_cnt + 1;
        start_dump(3'd0, 4'd12);
        wait_done(target);

        // Backpressure
        ready_mode = 1;
        push_stream(3'd0, 4'd2);
        target = done_cnt + 1;
        start_dump(3'd0, 4'd2);
        wait_done(target);
        ready_mode = 0;

        // Write to reg[3] lands before its LOAD
        target = done_cnt + 1;
        start_dump(3'd2, 4'd3);
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        push_stream(3'd2, 4'd3);
        wait_done(target);

        // Abort after the first handshake
        exp_q.push_back({1'b0, rf[0]});
        target = done_cnt;
        hs0 = hs_cnt;
        start_dump(3'd0, 4'd8);
        for (int i = 0; i < 50; i++) begin
            if (hs_cnt > hs0) break;
            @(posedge clk);
            #1;
        end
        chk("abort_first_hs", 32'(hs_cnt - hs0), 32'd1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_last",  32'(out_last),  32'd0);
        chk("abort_busy",  32'(busy),      32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt), 32'(target));
        push_stream(3'd0, 4'd8);
        target = done_cnt + 1;
        start_dump(3'd0, 4'd8);
        wait_done(target);

        // Reset while a byte is presented
        ready_mode = 2;
        @(posedge clk);
        #1;
        exp_q.push_back({1'b0, rf[4]});
        start_dump(3'd4, 4'd5);
        for (int i = 0; i < 20; i++) begin
            if (out_valid) break;
            @(posedge clk);
            #1;
        end
        chk("send_valid", 32'(out_valid), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst2_addr",  32'(rf_read_addr), 32'd0);
        chk("rst2_valid", 32'(out_valid),    32'd0);
        chk("rst2_data",  32'(out_data),     32'd0);
        chk("rst2_last",  32'(out_last),     32'd0);
        chk("rst2_busy",  32'(busy),         32'd0);
        chk("rst2_done",  32'(done),         32'd0);
        rst = 1'b0;
        exp_q.delete();
        ready_mode = 0;
        @(posedge clk);
        #1;

        // Start while busy is ignored
        push_stream(3'd1, 4'd2);
        target = done_cnt + 1;
        start_dump(3'd1, 4'd2);
        @(posedge clk);
        #1;
        start_dump(3'd5, 4'd1);
        wait_done(target);
        for (int i = 0; i < 3; i++) begin
            chk("no_queued_start", 32'(busy), 32'd0);
            @(posedge clk);
            #1;
        end

        // Start and abort together in IDLE
        abort = 1'b1;
        start_dump(3'd0, 4'd1);
        abort = 1'b0;
        chk("start_abort_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("start_abort_valid", 32'(out_valid), 32'd0);
        chk("start_abort_busy2", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
